// File: rtl/config_pkg.sv
// Shared constants and FSM state type for the serial configuration loader.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package config_pkg;

    localparam int CFG_DATA_W = 32;
    localparam int CFG_ADDR_W = 8;
    localparam logic [CFG_ADDR_W-1:0] BROADCAST_ADDR = 8'hFF;
    localparam int FRAME_BITS = 1 + CFG_ADDR_W + CFG_DATA_W;

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        DATA,
        COMMIT
    } cfg_state_t;

endpackage

// File: rtl/config_deserializer.sv
// MSB-first shift register with wrap-around bit counter; word includes the bit being shifted this cycle.
// Latency: word is combinational on the shifting cycle, registered afterwards.
// Backpressure: none; shifts only when shift_en is high, holds otherwise.
module config_deserializer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             shift_en,
    input  logic             bit_in,
    output logic [WIDTH-1:0] word,
    output logic             count_done
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [WIDTH-1:0] shift_q;
    logic [WIDTH-1:0] shift_d;
    logic [CNT_W-1:0] count_q;

    assign shift_d    = {shift_q[WIDTH-2:0], bit_in};
    assign count_done = shift_en && (count_q == CNT_W'(WIDTH - 1));
    // Exposing the pre-edge shifted value lets the caller commit on the same edge as the last bit.
    assign word       = shift_en ? shift_d : shift_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shift_q <= '0;
            count_q <= '0;
        end else begin
            if (shift_en) begin
                shift_q <= shift_d;
            end
            if (clear || count_done) begin
                count_q <= '0;
            end else if (shift_en) begin
                count_q <= count_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/config_loader.sv
// Deserializes start/addr/data frames from a bit stream and writes the word to the addressed tile(s).
// Latency: config_en/config_data update on the edge accepting the last data bit (one COMMIT cycle).
// Backpressure: cfg_ready drops only during COMMIT; source holds cfg_bit/cfg_valid while low.
module config_loader
    import config_pkg::*;
#(
    parameter int NUM_TILES = 16,
    parameter int ADDR_W    = CFG_ADDR_W,
    parameter int DATA_W    = CFG_DATA_W
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cfg_bit,
    input  logic                 cfg_valid,
    output logic                 cfg_ready,
    output logic [DATA_W-1:0]    config_data,
    output logic [NUM_TILES-1:0] config_en,
    output logic                 busy,
    output logic                 addr_err,
    output logic [15:0]          words_loaded
);

    cfg_state_t state_q;
    cfg_state_t state_d;

    logic addr_shift;
    logic addr_clr;
    logic addr_done;
    logic data_shift;
    logic data_clr;
    logic data_done;
    logic commit;

    logic [ADDR_W-1:0]    addr_word;
    logic [DATA_W-1:0]    data_word;
    logic [NUM_TILES-1:0] tile_sel;
    logic                 tile_hit;
    logic                 is_bcast;

    config_deserializer #(.WIDTH(ADDR_W)) u_addr_deser (
        .clk        (clk),
        .reset      (reset),
        .clear      (addr_clr),
        .shift_en   (addr_shift),
        .bit_in     (cfg_bit),
        .word       (addr_word),
        .count_done (addr_done)
    );

    config_deserializer #(.WIDTH(DATA_W)) u_data_deser (
        .clk        (clk),
        .reset      (reset),
        .clear      (data_clr),
        .shift_en   (data_shift),
        .bit_in     (cfg_bit),
        .word       (data_word),
        .count_done (data_done)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cfg_ready  = 1'b1;
        addr_shift = 1'b0;
        addr_clr   = 1'b0;
        data_shift = 1'b0;
        data_clr   = 1'b0;
        commit     = 1'b0;
        case (state_q)
            IDLE: begin
                if (cfg_valid && cfg_bit) begin
                    state_d  = ADDR;
                    addr_clr = 1'b1;
                end
            end
            ADDR: begin
                addr_shift = cfg_valid;
                if (addr_done) begin
                    state_d  = DATA;
                    data_clr = 1'b1;
                end
            end
            DATA: begin
                data_shift = cfg_valid;
                if (data_done) begin
                    state_d = COMMIT;
                    commit  = 1'b1;
                end
            end
            COMMIT: begin
                cfg_ready = 1'b0;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        tile_sel = '0;
        for (int i = 0; i < NUM_TILES; i++) begin
            tile_sel[i] = (addr_word == ADDR_W'(i));
        end
        tile_hit = |tile_sel;
        is_bcast = (addr_word == ADDR_W'(BROADCAST_ADDR));
    end

    // Outputs are loaded on the edge entering COMMIT so the pulse occupies exactly that cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            config_data  <= '0;
            config_en    <= '0;
            addr_err     <= 1'b0;
            words_loaded <= '0;
        end else begin
            config_en <= '0;
            if (commit) begin
                if (tile_hit || is_bcast) begin
                    config_data <= data_word;
                    config_en   <= tile_hit ? tile_sel : '1;
                    if (words_loaded != 16'hFFFF) begin
                        words_loaded <= words_loaded + 16'd1;
                    end
                end else begin
                    addr_err <= 1'b1;
                end
            end
        end
    end

    assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_config_loader.sv
// Bench for config_loader: directed scenarios plus randomized frames against a frame-level model.
module tb_config_loader;
    import config_pkg::*;

    localparam int NT = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          cfg_bit;
    logic          cfg_valid;
    logic          cfg_ready;
    logic [31:0]   config_data;
    logic [NT-1:0] config_en;
    logic          busy;
    logic          addr_err;
    logic [15:0]   words_loaded;

    config_loader #(.NUM_TILES(NT)) dut (
        .clk          (clk),
        .reset        (reset),
        .cfg_bit      (cfg_bit),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .config_data  (config_data),
        .config_en    (config_en),
        .busy         (busy),
        .addr_err     (addr_err),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    int tests_run = 0;
    int fails     = 0;

    // Pulse monitor: records every config_en pulse with its data and cycle number.
    int            cyc = 0;
    int            ready_low = 0;
    int            last_acc_cyc = 0;
    logic [NT-1:0] en_q[$];
    logic [31:0]   data_q[$];
    int            cyc_q[$];

    always @(negedge clk) begin
        cyc++;
        if (!cfg_ready) ready_low++;
        if (config_en != '0) begin
            en_q.push_back(config_en);
            data_q.push_back(config_data);
            cyc_q.push_back(cyc);
        end
    end

    // Frame-level reference model.
    logic [31:0] m_data;
    logic [15:0] m_words;
    logic        m_err;

    task automatic model_reset();
        m_data  = '0;
        m_words = '0;
        m_err   = 1'b0;
    endtask

    task automatic model_frame(input logic [7:0] a, input logic [31:0] d, output logic [NT-1:0] e);
        if (int'(a) < NT) begin
            e = NT'(1) << a;
        end else if (a == 8'hFF) begin
            e = '1;
        end else begin
            e = '0;
        end
        if (e != '0) begin
            m_data = d;
            if (m_words != 16'hFFFF) m_words = m_words + 16'd1;
        end else begin
            m_err = 1'b1;
        end
    endtask

    task automatic clear_mon();
        en_q.delete();
        data_q.delete();
        cyc_q.delete();
        ready_low = 0;
    endtask

    task automatic drive_bit(input logic b, input bit gap);
        logic r;
        int   n;
        if (gap) begin
            cfg_valid = 1'b0;
            cfg_bit   = 1'($urandom);
            @(posedge clk);
            #1;
        end
        cfg_valid = 1'b1;
        cfg_bit   = b;
        n = 0;
        do begin
            @(negedge clk);
            r = cfg_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!r && n < 50);
        if (!r) begin
            tests_run++;
            fails++;
            $display("FAIL drive_bit: cfg_ready stuck, got %b want 1", r);
        end
        last_acc_cyc = cyc;
    endtask

    // gap_mode: 0 = valid held high, 1 = valid low before every bit, 2 = random gaps
    task automatic send_frame(input logic [7:0] a, input logic [31:0] d, input int gap_mode);
        bit g;
        g = (gap_mode == 1) || (gap_mode == 2 && $urandom_range(0, 3) == 0);
        drive_bit(1'b1, g);
        for (int i = 7; i >= 0; i--) begin
            g = (gap_mode == 1) || (gap_mode == 2 && $urandom_range(0, 3) == 0);
            drive_bit(a[i], g);
        end
        for (int i = 31; i >= 0; i--) begin
            g = (gap_mode == 1) || (gap_mode == 2 && $urandom_range(0, 3) == 0);
            drive_bit(d[i], g);
        end
    endtask

    task automatic go_idle(input int n);
        cfg_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        cfg_valid = 1'b0;
        cfg_bit   = 1'b0;
        #2 reset  = 1'b0;
        repeat (2) @(posedge clk);
        #2 reset  = 1'b1;
        @(posedge clk);
        #1;
        model_reset();
    endtask

    task automatic test_reset();
        reset     = 1'b0;
        cfg_valid = 1'b0;
        cfg_bit   = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        tests_run++;
        if ({config_data, config_en, busy, addr_err, words_loaded} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: got data=%h en=%h busy=%b err=%b words=%0d want all zero",
                     config_data, config_en, busy, addr_err, words_loaded);
        end
        #1 reset = 1'b1;
        @(posedge clk);
        #1;
        tests_run++;
        if (cfg_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_ready: got %b want 1", cfg_ready);
        end
    endtask

    task automatic test_unicast();
        logic [NT-1:0] e;
        clear_mon();
        send_frame(8'h03, 32'hA5A5_0F0F, 0);
        model_frame(8'h03, 32'hA5A5_0F0F, e);
        go_idle(4);
        tests_run++;
        if (en_q.size() != 1) begin
            fails++;
            $display("FAIL unicast_pulses: got %0d want 1", en_q.size());
        end
        tests_run++;
        if ((en_q.size() > 0 ? en_q[0] : '0) !== 16'h0008) begin
            fails++;
            $display("FAIL unicast_en: got %h want 0008", en_q.size() > 0 ? en_q[0] : '0);
        end
        tests_run++;
        if ((data_q.size() > 0 ? data_q[0] : '0) !== 32'hA5A5_0F0F) begin
            fails++;
            $display("FAIL unicast_data: got %h want a5a50f0f", data_q.size() > 0 ? data_q[0] : '0);
        end
        tests_run++;
        if ((cyc_q.size() > 0 ? cyc_q[0] : -1) != last_acc_cyc + 1) begin
            fails++;
            $display("FAIL unicast_latency: pulse cycle %0d want %0d", cyc_q.size() > 0 ? cyc_q[0] : -1, last_acc_cyc + 1);
        end
        tests_run++;
        if (words_loaded !== 16'd1) begin
            fails++;
            $display("FAIL unicast_words: got %0d want 1", words_loaded);
        end
        tests_run++;
        if (ready_low != 1) begin
            fails++;
            $display("FAIL unicast_ready_low: got %0d cycles want 1", ready_low);
        end
        tests_run++;
        if (busy !== 1'b0 || config_en !== '0 || config_data !== m_data) begin
            fails++;
            $display("FAIL unicast_after: got busy=%b en=%h data=%h want 0/0/%h", busy, config_en, config_data, m_data);
        end
    endtask

    task automatic test_idle_gaps();
        logic [NT-1:0] e;
        clear_mon();
        for (int i = 0; i < 20; i++) drive_bit(1'b0, 1'b0);
        tests_run++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL idle_zeros_busy: got %b want 0", busy);
        end
        send_frame(8'h00, 32'hFFFF_FFFF, 1);
        model_frame(8'h00, 32'hFFFF_FFFF, e);
        go_idle(4);
        tests_run++;
        if (en_q.size() != 1 || en_q[0] !== 16'h0001 || data_q[0] !== 32'hFFFF_FFFF) begin
            fails++;
            $display("FAIL gaps_frame: got %0d pulses en=%h data=%h want 1 pulse en=0001 data=ffffffff",
                     en_q.size(), en_q.size() > 0 ? en_q[0] : '0, data_q.size() > 0 ? data_q[0] : '0);
        end
        tests_run++;
        if (words_loaded !== 16'd2 || busy !== 1'b0) begin
            fails++;
            $display("FAIL gaps_words: got words=%0d busy=%b want 2/0", words_loaded, busy);
        end
    endtask

    task automatic test_broadcast();
        logic [NT-1:0] e;
        clear_mon();
        send_frame(8'hFF, 32'h1234_5678, 0);
        model_frame(8'hFF, 32'h1234_5678, e);
        go_idle(4);
        tests_run++;
        if (en_q.size() != 1 || en_q[0] !== 16'hFFFF || data_q[0] !== 32'h1234_5678) begin
            fails++;
            $display("FAIL broadcast: got %0d pulses en=%h data=%h want 1 pulse en=ffff data=12345678",
                     en_q.size(), en_q.size() > 0 ? en_q[0] : '0, data_q.size() > 0 ? data_q[0] : '0);
        end
        tests_run++;
        if (words_loaded !== m_words) begin
            fails++;
            $display("FAIL broadcast_words: got %0d want %0d", words_loaded, m_words);
        end
    endtask

    task automatic test_bad_addr();
        logic [NT-1:0] e;
        logic [31:0]   d;
        d = $urandom;
        clear_mon();
        send_frame(8'h07, d, 0);
        model_frame(8'h07, d, e);
        go_idle(3);
        tests_run++;
        if (en_q.size() != 1 || en_q[0] !== 16'h0080 || config_data !== d) begin
            fails++;
            $display("FAIL pre_bad_frame: got %0d pulses data=%h want 1 pulse en=0080 data=%h", en_q.size(), config_data, d);
        end
        clear_mon();
        send_frame(8'h20, 32'hDEAD_BEEF, 0);
        model_frame(8'h20, 32'hDEAD_BEEF, e);
        go_idle(3);
        tests_run++;
        if (en_q.size() != 0) begin
            fails++;
            $display("FAIL bad_addr_pulse: got %0d pulses want 0", en_q.size());
        end
        tests_run++;
        if (config_data !== d || words_loaded !== m_words) begin
            fails++;
            $display("FAIL bad_addr_hold: got data=%h words=%0d want %h/%0d", config_data, words_loaded, d, m_words);
        end
        tests_run++;
        if (addr_err !== 1'b1) begin
            fails++;
            $display("FAIL bad_addr_err: got %b want 1", addr_err);
        end
        clear_mon();
        send_frame(8'h02, 32'h0BAD_F00D, 0);
        model_frame(8'h02, 32'h0BAD_F00D, e);
        go_idle(3);
        tests_run++;
        if (addr_err !== 1'b1 || en_q.size() != 1 || en_q[0] !== 16'h0004) begin
            fails++;
            $display("FAIL bad_addr_sticky: got err=%b pulses=%0d en=%h want 1/1/0004",
                     addr_err, en_q.size(), en_q.size() > 0 ? en_q[0] : '0);
        end
    endtask

    task automatic test_async_reset();
        logic [NT-1:0] e;
        logic [31:0]   d;
        d = 32'hC0FF_EE11;
        clear_mon();
        drive_bit(1'b1, 1'b0);
        for (int i = 7; i >= 0; i--) drive_bit(1'(8'h04 >> i), 1'b0);
        for (int i = 31; i >= 12; i--) drive_bit(d[i], 1'b0);
        #2;
        tests_run++;
        if (busy !== 1'b1) begin
            fails++;
            $display("FAIL async_pre_busy: got %b want 1", busy);
        end
        reset = 1'b0;
        #1;
        tests_run++;
        if ({config_data, config_en, busy, addr_err, words_loaded} !== '0) begin
            fails++;
            $display("FAIL async_clear: got data=%h en=%h busy=%b err=%b words=%0d want all zero",
                     config_data, config_en, busy, addr_err, words_loaded);
        end
        cfg_valid = 1'b0;
        @(posedge clk);
        #2 reset = 1'b1;
        model_reset();
        go_idle(3);
        tests_run++;
        if (en_q.size() != 0 || cfg_ready !== 1'b1) begin
            fails++;
            $display("FAIL async_no_pulse: got %0d pulses ready=%b want 0/1", en_q.size(), cfg_ready);
        end
        send_frame(8'h09, d, 0);
        model_frame(8'h09, d, e);
        go_idle(3);
        tests_run++;
        if (en_q.size() != 1 || en_q[0] !== 16'h0200 || config_data !== d || words_loaded !== 16'd1) begin
            fails++;
            $display("FAIL async_reload: got pulses=%0d data=%h words=%0d want 1/%h/1", en_q.size(), config_data, words_loaded, d);
        end
    endtask

    task automatic test_back_to_back();
        logic [NT-1:0] e;
        logic [31:0]   d1;
        logic [31:0]   d2;
        d1 = $urandom;
        d2 = $urandom;
        do_reset();
        clear_mon();
        send_frame(8'h05, d1, 0);
        send_frame(8'h06, d2, 0);
        model_frame(8'h05, d1, e);
        model_frame(8'h06, d2, e);
        go_idle(3);
        tests_run++;
        if (en_q.size() != 2) begin
            fails++;
            $display("FAIL b2b_pulses: got %0d want 2", en_q.size());
        end else begin
            tests_run++;
            if (en_q[0] !== 16'h0020 || en_q[1] !== 16'h0040 || data_q[0] !== d1 || data_q[1] !== d2) begin
                fails++;
                $display("FAIL b2b_content: got %h/%h %h/%h want 0020/%h 0040/%h", en_q[0], data_q[0], en_q[1], data_q[1], d1, d2);
            end
            tests_run++;
            if (cyc_q[1] - cyc_q[0] != FRAME_BITS + 1) begin
                fails++;
                $display("FAIL b2b_period: got %0d want %0d", cyc_q[1] - cyc_q[0], FRAME_BITS + 1);
            end
        end
        tests_run++;
        if (words_loaded !== 16'd2) begin
            fails++;
            $display("FAIL b2b_words: got %0d want 2", words_loaded);
        end
    endtask

    task automatic test_random();
        logic [NT-1:0] e;
        logic [7:0]    a;
        logic [31:0]   d;
        for (int k = 0; k < 12; k++) begin
            case ($urandom_range(0, 3))
                0, 1:    a = 8'($urandom_range(0, NT - 1));
                2:       a = 8'hFF;
                default: a = 8'($urandom_range(NT, 254));
            endcase
            d = $urandom;
            clear_mon();
            for (int z = $urandom_range(0, 3); z > 0; z--) drive_bit(1'b0, 1'b0);
            send_frame(a, d, 2);
            model_frame(a, d, e);
            go_idle(3);
            tests_run++;
            if (en_q.size() != (e != '0 ? 1 : 0) || (e != '0 && (en_q[0] !== e || data_q[0] !== d))) begin
                fails++;
                $display("FAIL rand_pulse[%0d]: addr=%h got pulses=%0d en=%h want en=%h data=%h",
                         k, a, en_q.size(), en_q.size() > 0 ? en_q[0] : '0, e, d);
            end
            tests_run++;
            if (config_data !== m_data || words_loaded !== m_words || addr_err !== m_err) begin
                fails++;
                $display("FAIL rand_state[%0d]: got data=%h words=%0d err=%b want %h/%0d/%b",
                         k, config_data, words_loaded, addr_err, m_data, m_words, m_err);
            end
        end
    endtask

    initial begin
        test_reset();
        test_unicast();
        test_idle_gaps();
        test_broadcast();
        test_bad_addr();
        test_async_reset();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout want completion");
        $fatal(1);
    end

endmodule
